spi_frame_packetizer: RTL and testbench

Upstream feeder for the SPI slave byte transmitter. Accepts 16-bit compressive-sensing measurement words over a valid/ready stream, buffers them, and packs them into framed byte sequences: sync, count, data bytes MSB first, checksum. It presents one byte at a time on `tx_byte` and advances on the transmitter's per-byte completion pulse. When no complete frame is buffered, it sends a fixed idle byte.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/meas_fifo.sv | 53 +++++
 rtl/spi_frame_packetizer.sv | 118 +++++++++++
 tb/tb_spi_frame_packetizer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame packetizer.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_COUNT,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CSUM
    } pkt_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

    // Bytes on the wire for one frame: sync, count, two per word, checksum.
    function automatic int frame_len(input int words);
        return 3 + 2 * words;
    endfunction

endpackage

// File: rtl/meas_fifo.sv
// Synchronous 16-bit word FIFO with registered fill count and first-word head output.
module meas_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [15:0]   wdata,
    output logic [15:0]   head,
    output logic [AW:0]   fill,
    output logic          full,
    output logic          empty
);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (fill == (AW+1)'(DEPTH));
    assign empty   = (fill == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/spi_frame_packetizer.sv
// Packs buffered measurement words into sync/count/data/checksum byte frames for the SPI slave.
module spi_frame_packetizer
    import spi_pkg::*;
#(
    parameter int         WORDS_PER_FRAME = 8,
    parameter int         FIFO_DEPTH      = 16,
    parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEF,
    parameter logic [7:0] IDLE_BYTE       = IDLE_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] meas_data,
    input  logic        meas_valid,
    output logic        meas_ready,
    input  logic        byte_sent,
    output logic [7:0]  tx_byte,
    output logic        frame_busy,
    output logic        frame_done
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] COUNT_B = 8'(WORDS_PER_FRAME);
    localparam logic [7:0] LAST_W  = 8'(WORDS_PER_FRAME - 1);

    pkt_state_t  state;
    logic [7:0]  word_cnt;
    logic [7:0]  csum;
    logic [15:0] head;
    logic [AW:0] fill;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        frame_avail;
    logic        adv;

    assign meas_ready  = !full;
    assign push        = meas_valid && meas_ready;
    assign adv         = byte_sent && !rst;
    assign pop         = adv && (state == ST_DATA_HI);
    assign frame_avail = !empty && (fill >= (AW+1)'(WORDS_PER_FRAME));

    meas_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (meas_data),
        .head  (head),
        .fill  (fill),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx_byte    <= IDLE_BYTE;
            word_cnt   <= '0;
            csum       <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (adv) begin
                case (state)
                    ST_IDLE, ST_CSUM: begin
                        frame_done <= (state == ST_CSUM);
                        if (frame_avail) begin
                            state      <= ST_SYNC;
                            tx_byte    <= SYNC_BYTE;
                            word_cnt   <= '0;
                            csum       <= '0;
                            frame_busy <= 1'b1;
                        end else begin
                            state      <= ST_IDLE;
                            tx_byte    <= IDLE_BYTE;
                            frame_busy <= 1'b0;
                        end
                    end
                    ST_SYNC: begin
                        state   <= ST_COUNT;
                        tx_byte <= COUNT_B;
                        csum    <= csum + COUNT_B;
                    end
                    ST_COUNT: begin
                        state   <= ST_DATA_HI;
                        tx_byte <= head[15:8];
                        csum    <= csum + head[15:8];
                    end
                    ST_DATA_HI: begin
                        state   <= ST_DATA_LO;
                        tx_byte <= head[7:0];
                        csum    <= csum + head[7:0];
                    end
                    ST_DATA_LO: begin
                        // The head was popped on DATA_LO entry, so it now shows the next word.
                        if (word_cnt == LAST_W) begin
                            state   <= ST_CSUM;
                            tx_byte <= csum;
                        end else begin
                            state    <= ST_DATA_HI;
                            tx_byte  <= head[15:8];
                            csum     <= csum + head[15:8];
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        tx_byte    <= IDLE_BYTE;
                        frame_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_packetizer.sv
// Scoreboard bench: pulse tasks queue the expected byte/flags, a monitor checks each boundary.
module tb_spi_frame_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] meas_data;
    logic        meas_valid;
    logic        meas_ready;
    logic        byte_sent;
    logic [7:0]  tx_byte;
    logic        frame_busy;
    logic        frame_done;

    typedef struct {
        logic [7:0] b;
        logic       done;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    spi_frame_packetizer #(.WORDS_PER_FRAME(2), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .meas_data  (meas_data),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .byte_sent  (byte_sent),
        .tx_byte    (tx_byte),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one cycle after each accepted boundary pulse the new byte and flags must be visible.
    always @(posedge clk) begin
        if (byte_sent === 1'b1 && rst === 1'b0) begin
            #1;
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tx_byte", {24'd0, tx_byte}, {24'd0, e.b});
                chk("frame_done", {31'd0, frame_done}, {31'd0, e.done});
                chk("frame_busy", {31'd0, frame_busy}, {31'd0, e.busy});
            end
        end
    end

    function automatic logic [7:0] csum2(input logic [15:0] w0, input logic [15:0] w1);
        return 8'(8'h02 + w0[15:8] + w0[7:0] + w1[15:8] + w1[7:0]);
    endfunction

    task automatic pulse(input logic [7:0] b, input logic d, input logic bz);
        exp_t e;
        e.b = b; e.done = d; e.busy = bz;
        q.push_back(e);
        @(negedge clk) byte_sent = 1'b1;
        @(negedge clk) byte_sent = 1'b0;
    endtask

    task automatic pulse_push(input logic [7:0] b, input logic d, input logic bz, input logic [15:0] w);
        exp_t e;
        e.b = b; e.done = d; e.busy = bz;
        q.push_back(e);
        @(negedge clk);
        byte_sent = 1'b1; meas_valid = 1'b1; meas_data = w;
        #1 chk("ready_at_simul_push", {31'd0, meas_ready}, 32'd1);
        @(negedge clk);
        byte_sent = 1'b0; meas_valid = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w, input logic exp_rdy);
        @(negedge clk);
        meas_valid = 1'b1; meas_data = w;
        #1 chk("meas_ready_push", {31'd0, meas_ready}, {31'd0, exp_rdy});
        @(negedge clk) meas_valid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] w0, input logic [15:0] w1, input logic first_done);
        pulse(8'hA5, first_done, 1'b1);
        pulse(8'h02, 1'b0, 1'b1);
        pulse(w0[15:8], 1'b0, 1'b1);
        pulse(w0[7:0], 1'b0, 1'b1);
        pulse(w1[15:8], 1'b0, 1'b1);
        pulse(w1[7:0], 1'b0, 1'b1);
        pulse(csum2(w0, w1), 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; meas_valid = 1'b0; meas_data = '0; byte_sent = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_tx_byte", {24'd0, tx_byte}, 32'hFF);
        chk("rst_meas_ready", {31'd0, meas_ready}, 32'd1);
        chk("rst_frame_busy", {31'd0, frame_busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // Idle with no words buffered.
        repeat (3) pulse(8'hFF, 1'b0, 1'b0);

        // Single frame, hand-computed checksum C0.
        push_word(16'h1234, 1'b1);
        push_word(16'hABCD, 1'b1);
        pulse(8'hA5, 0, 1); pulse(8'h02, 0, 1); pulse(8'h12, 0, 1); pulse(8'h34, 0, 1);
        pulse(8'hAB, 0, 1); pulse(8'hCD, 0, 1); pulse(8'hC0, 0, 1);
        pulse(8'hFF, 1, 0);
        @(negedge clk);
        chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);

        // Back-to-back frames: checksums 0C and 68.
        push_word(16'h0102, 1'b1);
        push_word(16'h0304, 1'b1);
        push_word(16'h1111, 1'b1);
        push_word(16'h2222, 1'b1);
        pulse(8'hA5, 0, 1); pulse(8'h02, 0, 1); pulse(8'h01, 0, 1); pulse(8'h02, 0, 1);
        pulse(8'h03, 0, 1); pulse(8'h04, 0, 1); pulse(8'h0C, 0, 1);
        pulse(8'hA5, 1, 1); pulse(8'h02, 0, 1); pulse(8'h11, 0, 1); pulse(8'h11, 0, 1);
        pulse(8'h22, 0, 1); pulse(8'h22, 0, 1); pulse(8'h68, 0, 1);
        pulse(8'hFF, 1, 0);

        // Fill the buffer completely; the extra word must be refused.
        for (int i = 0; i < 16; i++) push_word(16'h1000 + 16'(i), 1'b1);
        #1 chk("full_ready_low", {31'd0, meas_ready}, 32'd0);
        push_word(16'hDEAD, 1'b0);
        pulse(8'hA5, 0, 1); pulse(8'h02, 0, 1); pulse(8'h10, 0, 1); pulse(8'h00, 0, 1);
        chk("ready_after_pop", {31'd0, meas_ready}, 32'd1);
        pulse(8'h10, 0, 1);
        pulse_push(8'h01, 0, 1, 16'hBEEF);
        chk("ready_after_simul", {31'd0, meas_ready}, 32'd1);
        pulse(csum2(16'h1000, 16'h1001), 0, 1);
        for (int k = 1; k < 8; k++) frame(16'h1000 + 16'(2*k), 16'h1001 + 16'(2*k), 1'b1);
        pulse(8'hFF, 1, 0);
        pulse(8'hFF, 0, 0);
        push_word(16'hCAFE, 1'b1);
        frame(16'hBEEF, 16'hCAFE, 1'b0);
        pulse(8'hFF, 1, 0);

        // Reset in DATA_HI with a coincident pulse; the buffer must be flushed.
        push_word(16'h5555, 1'b1);
        push_word(16'h6666, 1'b1);
        pulse(8'hA5, 0, 1); pulse(8'h02, 0, 1); pulse(8'h55, 0, 1);
        @(negedge clk);
        rst = 1'b1; byte_sent = 1'b1;
        @(negedge clk);
        rst = 1'b0; byte_sent = 1'b0;
        #1;
        chk("midrst_tx_byte", {24'd0, tx_byte}, 32'hFF);
        chk("midrst_busy", {31'd0, frame_busy}, 32'd0);
        chk("midrst_ready", {31'd0, meas_ready}, 32'd1);
        chk("midrst_done", {31'd0, frame_done}, 32'd0);
        pulse(8'hFF, 0, 0);
        push_word(16'h0F0F, 1'b1);
        push_word(16'h0101, 1'b1);
        frame(16'h0F0F, 16'h0101, 1'b0);
        chk("fresh_csum_hand", {24'd0, csum2(16'h0F0F, 16'h0101)}, 32'h22);
        pulse(8'hFF, 1, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
